// File: rtl/mix_pipe_if.sv
`default_nettype none
// ============================================================================
// Module : mix_pipe_if
// Brief  : Handshake bundle for mix_pipe. The input channel carries words and
//          their mode, and the output channel carries results and the
//          completed-transfer count.
// Rev    : 1.0  initial release
// ============================================================================
interface mix_pipe_if #(
  parameter int LANES = 1
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_mode;
  logic [16*LANES-1:0]  in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [16*LANES-1:0]  out_data;
  logic                 out_mode;
  logic [15:0]          out_count;

  // Producer/consumer side (bench or surrounding datapath)
  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_mode, out_count
  );

  // Mixing pipeline side
  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_mode, out_count
  );
endinterface
`default_nettype wire

// File: rtl/mix_pipe.sv
`default_nettype none
// ============================================================================
// Module : mix_pipe
// Brief  : Two-step Hummingbird-2 style mixing pipeline. Forward words go
//          S then L, and inverse words go L^-1 then S^-1, so both directions
//          share the same two register stages. The optional output register
//          is selected by REG_OUT. Full valid/ready backpressure is supported.
// Rev    : 1.0  initial release
// ============================================================================
module mix_pipe #(
  parameter int LANES   = 1,
  parameter int REG_OUT = 1
) (
  input  wire logic  clk,
  input  wire logic  rst,
  mix_pipe_if.slave  bus
);

  localparam int W = 16 * LANES;

  // S-box tables, nibble i of the table sits at bits [4i+3:4i]
  localparam logic [63:0] C_S1  = 64'h3A840D6BF5129EC7;
  localparam logic [63:0] C_S2  = 64'h2B95DE03C7F861A4;
  localparam logic [63:0] C_S3  = 64'h79B0438EDA651CF2;
  localparam logic [63:0] C_S4  = 64'hBDC6E03A1279854F;
  localparam logic [63:0] C_S1I = 64'h72A18E3D096CF45B;
  localparam logic [63:0] C_S2I = 64'h5AB7E1D463C08F29;
  localparam logic [63:0] C_S3I = 64'h1872D6E9F54BA03C;
  localparam logic [63:0] C_S4I = 64'h0BEDF8435C21967A;

  function automatic logic [3:0] lut(input logic [63:0] t, input logic [3:0] n);
    return t[{n, 2'b00} +: 4];
  endfunction

  function automatic logic [15:0] sub_fwd(input logic [15:0] x);
    return {lut(C_S1, x[15:12]), lut(C_S2, x[11:8]), lut(C_S3, x[7:4]), lut(C_S4, x[3:0])};
  endfunction

  function automatic logic [15:0] sub_inv(input logic [15:0] x);
    return {lut(C_S1I, x[15:12]), lut(C_S2I, x[11:8]), lut(C_S3I, x[7:4]), lut(C_S4I, x[3:0])};
  endfunction

  // x ^ rotl(x,6) ^ rotl(x,10)
  function automatic logic [15:0] lin_fwd(input logic [15:0] x);
    return x ^ {x[9:0], x[15:10]} ^ {x[5:0], x[15:6]};
  endfunction

  // y ^ rotl(y,2) ^ rotl(y,4) ^ rotl(y,12) ^ rotl(y,14)
  function automatic logic [15:0] lin_inv(input logic [15:0] y);
    return y ^ {y[13:0], y[15:14]} ^ {y[11:0], y[15:12]}
             ^ {y[3:0], y[15:4]} ^ {y[1:0], y[15:2]};
  endfunction

  logic          in_fire;
  logic          s1_take;
  logic          s1_valid_q, s1_valid_d;
  logic          s1_mode_q,  s1_mode_d;
  logic [W-1:0]  s1_data_q,  s1_data_d;
  logic [W-1:0]  stage1_fn;
  logic [W-1:0]  stage2_fn;
  logic [15:0]   out_count_q, out_count_d;

  assign in_fire = bus.in_valid && bus.in_ready;

  // Stage-1 transform: S for forward words, L^-1 for inverse words
  always_comb begin
    stage1_fn = '0;
    for (int k = 0; k < LANES; k++) begin
      stage1_fn[16*k +: 16] = bus.in_mode ? lin_inv(bus.in_data[16*k +: 16])
                                          : sub_fwd(bus.in_data[16*k +: 16]);
    end
  end

  // Stage-2 transform on the stage-1 register: L forward, S^-1 inverse
  always_comb begin
    stage2_fn = '0;
    for (int k = 0; k < LANES; k++) begin
      stage2_fn[16*k +: 16] = s1_mode_q ? sub_inv(s1_data_q[16*k +: 16])
                                        : lin_fwd(s1_data_q[16*k +: 16]);
    end
  end

  // Stage-1 next state: load on accept, otherwise empty once its word leaves
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_data_d  = s1_data_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_mode_d  = bus.in_mode;
      s1_data_d  = stage1_fn;
    end else if (s1_take) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage-1 register
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mode_q  <= s1_mode_d;
      s1_data_q  <= s1_data_d;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic          s2_free;
      logic          s2_valid_q, s2_valid_d;
      logic          s2_mode_q,  s2_mode_d;
      logic [W-1:0]  s2_data_q,  s2_data_d;

      // s2 can take a word if empty or draining this cycle; the ready path
      // is combinational from out_ready so a full pipe still streams.
      assign s2_free      = !s2_valid_q || bus.out_ready;
      assign s1_take      = s1_valid_q && s2_free;
      assign bus.in_ready = !s1_valid_q || s2_free;

      // Stage-2 next state: capture the stage-2 result or drain on handoff
      always_comb begin
        s2_valid_d = s2_valid_q;
        s2_mode_d  = s2_mode_q;
        s2_data_d  = s2_data_q;
        if (s1_take) begin
          s2_valid_d = 1'b1;
          s2_mode_d  = s1_mode_q;
          s2_data_d  = stage2_fn;
        end else if (bus.out_ready) begin
          s2_valid_d = 1'b0;
        end
      end

      // Stage-2 (output) register
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid_q <= 1'b0;
          s2_mode_q  <= 1'b0;
          s2_data_q  <= '0;
        end else begin
          s2_valid_q <= s2_valid_d;
          s2_mode_q  <= s2_mode_d;
          s2_data_q  <= s2_data_d;
        end
      end

      assign bus.out_valid = s2_valid_q;
      assign bus.out_mode  = s2_mode_q;
      assign bus.out_data  = s2_data_q;
    end else begin : g_comb_out
      // Stage 2 is pure logic on s1; a cleared s1 (mode 0, data 0) maps to
      // L(0) = 0, so out_data still reads zero after reset.
      assign s1_take       = s1_valid_q && bus.out_ready;
      assign bus.in_ready  = !s1_valid_q || bus.out_ready;
      assign bus.out_valid = s1_valid_q;
      assign bus.out_mode  = s1_mode_q;
      assign bus.out_data  = stage2_fn;
    end
  endgenerate

  // Completed-transfer counter, wraps silently
  always_comb begin
    out_count_d = out_count_q;
    if (bus.out_valid && bus.out_ready) begin
      out_count_d = out_count_q + 16'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_count_q <= 16'd0;
    end else begin
      out_count_q <= out_count_d;
    end
  end

  assign bus.out_count = out_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mix_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_mix_pipe
// Brief  : Self-checking bench for mix_pipe. Three instances are used:
//          (LANES=1, REG_OUT=1), (LANES=4, REG_OUT=1) and (LANES=1, REG_OUT=0).
// Rev    : 1.0  initial release
// ============================================================================
module tb_mix_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mix_pipe_if #(.LANES(1)) ifa ();
  mix_pipe_if #(.LANES(4)) ifb ();
  mix_pipe_if #(.LANES(1)) ifc ();

  mix_pipe #(.LANES(1), .REG_OUT(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  mix_pipe #(.LANES(4), .REG_OUT(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  mix_pipe #(.LANES(1), .REG_OUT(0)) dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

  // Per-instance drive and observe arrays (index 0=a, 1=b, 2=c)
  logic        drv_iv [3];
  logic        drv_mode [3];
  logic [63:0] drv_data [3];
  logic        drv_or [3];
  logic        mon_ir [3];
  logic        mon_ov [3];
  logic        mon_om [3];
  logic [63:0] mon_od [3];
  logic [15:0] mon_cnt [3];

  assign ifa.in_valid = drv_iv[0];  assign ifa.in_mode = drv_mode[0];
  assign ifa.in_data  = drv_data[0][15:0];  assign ifa.out_ready = drv_or[0];
  assign ifb.in_valid = drv_iv[1];  assign ifb.in_mode = drv_mode[1];
  assign ifb.in_data  = drv_data[1];        assign ifb.out_ready = drv_or[1];
  assign ifc.in_valid = drv_iv[2];  assign ifc.in_mode = drv_mode[2];
  assign ifc.in_data  = drv_data[2][15:0];  assign ifc.out_ready = drv_or[2];

  assign mon_ir[0] = ifa.in_ready;  assign mon_ov[0] = ifa.out_valid;
  assign mon_om[0] = ifa.out_mode;  assign mon_od[0] = {48'h0, ifa.out_data};
  assign mon_cnt[0] = ifa.out_count;
  assign mon_ir[1] = ifb.in_ready;  assign mon_ov[1] = ifb.out_valid;
  assign mon_om[1] = ifb.out_mode;  assign mon_od[1] = ifb.out_data;
  assign mon_cnt[1] = ifb.out_count;
  assign mon_ir[2] = ifc.in_ready;  assign mon_ov[2] = ifc.out_valid;
  assign mon_om[2] = ifc.out_mode;  assign mon_od[2] = {48'h0, ifc.out_data};
  assign mon_cnt[2] = ifc.out_count;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out", name);
  endtask

  // ---------------- reference model ----------------
  int sbox_t [4][16] = '{
    '{ 7, 12, 14,  9,  2,  1,  5, 15, 11,  6, 13,  0,  4,  8, 10,  3},
    '{ 4, 10,  1,  6,  8, 15,  7, 12,  3,  0, 14, 13,  5,  9, 11,  2},
    '{ 2, 15, 12,  1,  5,  6, 10, 13, 14,  8,  3,  4,  0, 11,  9,  7},
    '{15,  4,  5,  8,  9,  7,  2,  1, 10,  3,  0, 14,  6, 12, 13, 11}
  };

  function automatic int m_sub(input int x, input bit inv);
    int r;
    r = 0;
    for (int j = 0; j < 4; j++) begin
      int nib, v;
      nib = (x >> (12 - 4*j)) & 15;
      v = 0;
      if (!inv) v = sbox_t[j][nib];
      else for (int c = 0; c < 16; c++) if (sbox_t[j][c] == nib) v = c;
      r = r | (v << (12 - 4*j));
    end
    return r;
  endfunction

  function automatic int m_rotl(input int x, input int n);
    return ((x << n) | (x >> (16 - n))) & 32'hFFFF;
  endfunction

  function automatic int m_lin(input int x);
    return x ^ m_rotl(x, 6) ^ m_rotl(x, 10);
  endfunction

  function automatic int m_lininv(input int y);
    return y ^ m_rotl(y, 2) ^ m_rotl(y, 4) ^ m_rotl(y, 12) ^ m_rotl(y, 14);
  endfunction

  function automatic logic [15:0] m_mix(input int x, input bit inv);
    int r;
    r = inv ? m_sub(m_lininv(x), 1'b1) : m_lin(m_sub(x, 1'b0));
    return r[15:0];
  endfunction

  function automatic logic [64:0] m_xfer(input int lanes, input bit mode, input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < lanes; k++) r[16*k +: 16] = m_mix(int'(d[16*k +: 16]), mode);
    return {mode, r};
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic [64:0] exp_q [3][$];
  logic [63:0] cap_q [3][$];
  logic [15:0] cnt_exp [3];
  bit          hold [3];
  logic [64:0] held [3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        exp_q[i].delete();
        cnt_exp[i] = 16'd0;
        hold[i] = 1'b0;
      end else begin
        int lanes, cap;
        lanes = (i == 1) ? 4 : 1;
        cap   = (i == 2) ? 1 : 2;
        check("count", {49'h0, mon_cnt[i]}, {49'h0, cnt_exp[i]});
        check("in_ready", {64'h0, mon_ir[i]},
              {64'h0, (exp_q[i].size() < cap) || drv_or[i]});
        if (hold[i]) begin
          check("hold_valid", {64'h0, mon_ov[i]}, 65'h1);
          check("hold_data", {mon_om[i], mon_od[i]}, held[i]);
        end
        if (mon_ov[i]) begin
          if (exp_q[i].size() == 0) check("out_valid_empty", {64'h0, mon_ov[i]}, 65'h0);
          else check("out_data", {mon_om[i], mon_od[i]}, exp_q[i][0]);
        end
        if (mon_ov[i] && drv_or[i]) begin
          if (exp_q[i].size() > 0) void'(exp_q[i].pop_front());
          cap_q[i].push_back(mon_od[i]);
          cnt_exp[i] = cnt_exp[i] + 16'd1;
        end
        hold[i] = mon_ov[i] && !drv_or[i];
        held[i] = {mon_om[i], mon_od[i]};
        if (drv_iv[i] && mon_ir[i])
          exp_q[i].push_back(m_xfer(lanes, drv_mode[i], drv_data[i]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input int i, input bit mode, input logic [63:0] d);
    bit acc;
    drv_iv[i] = 1'b1;  drv_mode[i] = mode;  drv_data[i] = d;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      acc = mon_ir[i];
      tick();
      if (acc) begin
        drv_iv[i] = 1'b0;
        return;
      end
    end
    drv_iv[i] = 1'b0;
    fail_now("send");
  endtask

  task automatic wait_caps(input int i, input int n);
    for (int t = 0; t < 40; t++) begin
      if (cap_q[i].size() >= n) return;
      tick();
    end
    fail_now("drain");
  endtask

  typedef struct {
    bit          mode;
    logic [15:0] din;
    logic [15:0] dout;
  } vec_t;

  vec_t        tbl [6];
  int          sent;
  logic [15:0] bpw [3];
  logic [15:0] xs [1000];
  logic [63:0] ys [$];

  initial begin
    tbl[0] = '{1'b0, 16'h0000, 16'hC222};
    tbl[1] = '{1'b1, 16'hC222, 16'h0000};
    tbl[2] = '{1'b0, 16'hFFFF, m_mix(32'hFFFF, 1'b0)};
    tbl[3] = '{1'b1, 16'h0000, m_mix(32'h0000, 1'b1)};
    tbl[4] = '{1'b0, 16'h1234, m_mix(32'h1234, 1'b0)};
    tbl[5] = '{1'b1, 16'hABCD, m_mix(32'hABCD, 1'b1)};

    for (int i = 0; i < 3; i++) begin
      drv_iv[i] = 1'b0; drv_mode[i] = 1'b0; drv_data[i] = '0; drv_or[i] = 1'b1;
    end
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", {64'h0, mon_ov[0]}, 65'h0);
    check("rst_out_data",  {1'b0, mon_od[0]},  65'h0);
    check("rst_out_mode",  {64'h0, mon_om[0]}, 65'h0);
    check("rst_count",     {49'h0, mon_cnt[0]}, 65'h0);
    check("rst_in_ready",  {64'h0, mon_ir[0]}, 65'h1);
    check("rst_c_data",    {1'b0, mon_od[2]},  65'h0);
    tick();

    // Table vectors with latency check, REG_OUT=1
    for (int v = 0; v < 6; v++) begin
      drv_iv[0] = 1'b1; drv_mode[0] = tbl[v].mode; drv_data[0] = {48'h0, tbl[v].din};
      @(negedge clk);
      check("tbl_ready", {64'h0, mon_ir[0]}, 65'h1);
      tick();
      drv_iv[0] = 1'b0;
      @(negedge clk);
      check("tbl_lat_n1", {64'h0, mon_ov[0]}, 65'h0);
      tick();
      @(negedge clk);
      check("tbl_lat_n2", {64'h0, mon_ov[0]}, 65'h1);
      check("tbl_out", {mon_om[0], mon_od[0]}, {tbl[v].mode, 48'h0, tbl[v].dout});
      tick();
    end
    @(negedge clk);
    check("tbl_count", {49'h0, mon_cnt[0]}, 65'd6);
    tick();

    // REG_OUT=0: result one edge after accept
    drv_iv[2] = 1'b1; drv_mode[2] = 1'b0; drv_data[2] = 64'h0;
    tick();
    drv_iv[2] = 1'b0;
    @(negedge clk);
    check("comb_valid", {64'h0, mon_ov[2]}, 65'h1);
    check("comb_data", {1'b0, mon_od[2]}, {49'h0, 16'hC222});
    tick();

    // LANES=4, mixed modes back to back
    drv_iv[1] = 1'b1; drv_mode[1] = 1'b0; drv_data[1] = 64'h0;
    tick();
    drv_mode[1] = 1'b1; drv_data[1] = {4{16'hC222}};
    @(negedge clk);
    check("mix_lat_n1", {64'h0, mon_ov[1]}, 65'h0);
    tick();
    drv_iv[1] = 1'b0;
    @(negedge clk);
    check("mix_out1", {mon_ov[1], mon_om[1], mon_od[1]}, {1'b1, 1'b0, {4{16'hC222}}});
    tick();
    @(negedge clk);
    check("mix_out2", {mon_ov[1], mon_om[1], mon_od[1]}, {1'b1, 1'b1, 64'h0});
    tick();

    // Backpressure: three words against a stalled sink
    do_reset();
    bpw[0] = 16'h1111; bpw[1] = 16'h2222; bpw[2] = 16'h3333;
    drv_or[0] = 1'b0; sent = 0;
    for (int c = 0; c < 5; c++) begin
      drv_iv[0] = 1'b1; drv_mode[0] = 1'b0; drv_data[0] = {48'h0, bpw[sent]};
      @(negedge clk);
      if (mon_ir[0]) sent++;
      tick();
    end
    check("bp_accepts", 65'(sent), 65'd2);
    @(negedge clk);
    check("bp_stall_ready", {64'h0, mon_ir[0]}, 65'h0);
    check("bp_stall_data", {1'b0, mon_od[0]}, {49'h0, m_mix(int'(bpw[0]), 1'b0)});
    tick();
    drv_or[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (sent < 3) begin
        drv_iv[0] = 1'b1; drv_data[0] = {48'h0, bpw[sent]};
      end else begin
        drv_iv[0] = 1'b0;
      end
      @(negedge clk);
      if (drv_iv[0] && mon_ir[0]) sent++;
      tick();
    end
    drv_iv[0] = 1'b0;
    check("bp_sent", 65'(sent), 65'd3);
    @(negedge clk);
    check("bp_count", {49'h0, mon_cnt[0]}, 65'd3);
    tick();

    // Reset with two words in flight; a word offered on the reset edge is dropped
    drv_or[0] = 1'b0;
    send(0, 1'b0, 64'h00AA);
    send(0, 1'b1, 64'h00BB);
    rst = 1'b1; drv_iv[0] = 1'b1; drv_data[0] = 64'h5555; drv_or[0] = 1'b1;
    tick();
    rst = 1'b0; drv_iv[0] = 1'b0;
    @(negedge clk);
    check("mrst_valid", {64'h0, mon_ov[0]}, 65'h0);
    check("mrst_data",  {1'b0, mon_od[0]},  65'h0);
    check("mrst_count", {49'h0, mon_cnt[0]}, 65'h0);
    check("mrst_ready", {64'h0, mon_ir[0]}, 65'h1);
    tick();
    @(negedge clk);
    check("mrst_drop", {64'h0, mon_ov[0]}, 65'h0);
    tick();
    tick();

    // Round trip F^-1(F(x)) = x over 1000 words
    cap_q[0].delete();
    xs[0] = 16'h0000;
    for (int k = 1; k < 1000; k++) xs[k] = 16'($urandom);
    for (int k = 0; k < 1000; k++) send(0, 1'b0, {48'h0, xs[k]});
    wait_caps(0, 1000);
    ys = cap_q[0];
    cap_q[0].delete();
    foreach (ys[k]) send(0, 1'b1, ys[k]);
    wait_caps(0, 1000);
    for (int k = 0; k < 1000; k++) begin
      if (k < cap_q[0].size())
        check("round_trip", {1'b0, cap_q[0][k]}, {49'h0, xs[k]});
    end

    // Random traffic on all three instances with random backpressure
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 3; i++) begin
        drv_iv[i]   = ($urandom_range(3) != 0);
        drv_mode[i] = 1'($urandom);
        drv_data[i] = {32'($urandom), 32'($urandom)};
        drv_or[i]   = ($urandom_range(3) != 0);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drv_iv[i] = 1'b0; drv_or[i] = 1'b1;
    end
    tick(); tick(); tick();
    for (int i = 0; i < 3; i++) check("rand_drained", 65'(exp_q[i].size()), 65'd0);

    // Counter wrap after 65536 transfers
    do_reset();
    for (int c = 0; c < 65536; c++) begin
      drv_iv[0] = 1'b1; drv_mode[0] = 1'($urandom); drv_data[0] = {48'h0, 16'($urandom)};
      tick();
    end
    drv_iv[0] = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    check("wrap_count", {49'h0, mon_cnt[0]}, 65'h0);
    check("wrap_valid", {64'h0, mon_ov[0]}, 65'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mix_pipe.md
# mix_pipe

Parametrised, pipelined successor to the Hummingbird-2 mixing function. Applies the forward mix F(x) = L(S(x)) or its inverse F⁻¹(y) = S⁻¹(L⁻¹(y)) to LANES independent 16-bit words per transfer. It uses a valid/ready handshake with full backpressure. It sits between the round-key XOR logic and the round state registers of the encrypt/decrypt datapath.

## Interface
- LANES, default 1: number of parallel 16-bit words per transfer, 1..8.
- REG_OUT, default 1: 1 = registered L stage, latency 2; 0 = combinational L on the stage-1 register, latency 1.
- clk  in  1  rising-edge clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word(s) present.
- in_ready  out  1  block can accept this cycle.
- in_mode  in  1  0 = forward F, 1 = inverse F⁻¹; sampled with in_data.
- in_data  in  16*LANES  lane k = bits [16k+15:16k].
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts.
- out_data  out  16*LANES  result, lane-aligned with in_data.
- out_mode  out  1  mode the result was computed with.
- out_count  out  16  completed output transfers, wraps 0xFFFF→0x0000.

## Operation
- S layer: four 4-bit S-boxes per lane, nibble [15:12]→S1, [11:8]→S2, [7:4]→S3, [3:0]→S4. Table values are listed in hex, inputs 0..F.
  - S1 = 7 C E 9 2 1 5 F B 6 D 0 4 8 A 3
  - S2 = 4 A 1 6 8 F 7 C 3 0 E D 5 9 B 2
  - S3 = 2 F C 1 5 6 A D E 8 3 4 0 B 9 7
  - S4 = F 4 5 8 9 7 2 1 A 3 0 E 6 C D B
  - S⁻¹ tables are the exact inverses of these.
- Linear layers, rotl = 16-bit rotate left:
  - L(x) = x ^ rotl(x,6) ^ rotl(x,10).
  - L⁻¹(y) = y ^ rotl(y,2) ^ rotl(y,4) ^ rotl(y,12) ^ rotl(y,14).
- Stage 1 register (s1_data, s1_mode, s1_valid):
  - Forward: loads S(in_data).
  - Inverse: loads L⁻¹(in_data).
- Stage 2, REG_OUT=1 (s2_data, s2_mode, s2_valid):
  - Forward: loads L(s1_data).
  - Inverse: loads S⁻¹(s1_data).
- REG_OUT=0: the stage-2 function is applied combinationally to s1 outputs; out_valid = s1_valid.
- Mode is per transfer. Consecutive transfers may alternate modes with no bubble or flush.
- All lanes use the same in_mode.
- Handshake:
  - Transfer occurs when valid && ready on the same edge.
  - in_data and in_mode are don't-care when in_valid=0.
  - out_data and out_mode stay stable while out_valid=1 && out_ready=0.
- Backpressure (REG_OUT=1):
  - s2_free = !s2_valid || out_ready.
  - s1 advances into s2 when s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free. This path is combinational from out_ready.
- Backpressure (REG_OUT=0): in_ready = !s1_valid || out_ready.
- out_count increments by 1 on each out_valid && out_ready edge.

## Timing
- Reset, synchronous, wins over every other event on the same edge:
  - All valids clear.
  - s1/s2 data and mode clear to 0.
  - out_count = 0.
  - out_valid = 0, out_data = 0, out_mode = 0.
  - in_ready = 1 from the first cycle after reset.
  - A transfer presented on the reset edge is dropped and not counted.
- Reset mid-stream discards all in-flight words. No partial output is produced.
- Latency: accept at edge N → out_valid at edge N+2 (REG_OUT=1) or N+1 (REG_OUT=0).
- Throughput: 1 transfer per cycle while out_ready=1.
- Full pipeline (REG_OUT=1, both stages valid, out_ready=0): in_ready=0, contents held.
  - Releasing out_ready for 1 cycle frees exactly one slot.
- Simultaneous output and input on a full pipe: both occur, pipeline shifts, and occupancy is unchanged.
- out_count wraps silently at 0xFFFF and has no overflow flag.

## Test plan
- Forward, LANES=1, REG_OUT=1: in_data=0x0000, mode 0 → out_data=0xC222 at edge N+2. Intermediate S value is 0x742F. out_count=1.
- Inverse round trip: in_data=0xC222, mode 1 → 0x0000. Then 0x0000 → fwd → inv (two transfers chained via the bench) returns 0x0000. Repeat with 1000 random words: F⁻¹(F(x))=x for every x.
- Mixed modes back-to-back, LANES=4:
  - Transfer 1: lanes {0x0000,0x0000,0x0000,0x0000} fwd.
  - Transfer 2: lanes {0xC222,…} inv, on consecutive cycles.
  - Required: outputs {0xC222×4} then {0x0000×4} on consecutive cycles, out_mode 0 then 1.
- Backpressure: hold out_ready=0 and stream 3 words.
  - Required: in_ready drops after 2 accepts, out_data stable, nothing lost or duplicated.
  - Release out_ready: all 3 emerge in order, out_count=3.
- Reset mid-operation: 2 words in flight, assert rst for 1 cycle.
  - Required next cycle: out_valid=0, out_data=0, out_count=0, in_ready=1.
- REG_OUT=0: in_data=0x0000 fwd → 0xC222 at edge N+1.
- Counter wrap: preload via 65536 transfers → out_count returns to 0x0000.
